// File: rtl/buf_fifo.sv
// buf_fifo: parametrised single-clock FIFO between the instruction-side
// producer and the execute-side consumer.
//
// Build option: define BUF_FIFO_FWFT_EN for first-word-fall-through output
// (rd_data shows the head combinationally, rd_valid = !empty, rd_en pops).
// Without it, rd_data is a register loaded on an accepted read and rd_valid
// is a one-cycle pulse aligned with the loaded word.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous clear of pointers, flags and rd_valid
//   wr_en, wr_data     write request and data (dropped while full)
//   rd_en              read request (ignored while empty)
//   rd_data, rd_valid  read data and its valid qualifier
//   full, empty        occupancy == DEPTH / occupancy == 0
//   almost_full        occupancy >= AF_LVL
//   count              occupancy, 0..DEPTH
//   ovf, udf           sticky overflow / underflow, cleared by flush or reset
module buf_fifo #(
    parameter int DW     = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH),
    parameter int AF_LVL = DEPTH - 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wp_q, wp_d;
    logic [AW:0]   rp_q, rp_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc;
    logic          rd_acc;
    logic [DW-1:0] ram_q [DEPTH];

    assign empty       = (wp_q == rp_q);
    assign full        = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign count       = wp_q - rp_q;
    assign almost_full = (count >= (AW+1)'(AF_LVL));
    assign ovf         = ovf_q;
    assign udf         = udf_q;

    // Acceptance looks only at registered status: no bypass in either
    // direction, and flush suppresses both requests.
    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (wr_acc)         wp_d  = wp_q + (AW+1)'(1);
            if (rd_acc)         rp_d  = rp_q + (AW+1)'(1);
            if (wr_en && full)  ovf_d = 1'b1;
            if (rd_en && empty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) ram_q[wp_q[AW-1:0]] <= wr_data;
    end

`ifdef BUF_FIFO_FWFT_EN
    assign rd_data  = ram_q[rp_q[AW-1:0]];
    assign rd_valid = ~empty;
`else
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) rd_data_d = ram_q[rp_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_buf_fifo.sv
// Testbench for buf_fifo. Follows BUF_FIFO_FWFT_EN: when defined the FIFO is
// built as DW=8, DEPTH=4 in fall-through mode, otherwise DW=32, DEPTH=16.
module tb_buf_fifo;

`ifdef BUF_FIFO_FWFT_EN
    localparam int DW    = 8;
    localparam int DEPTH = 4;
`else
    localparam int DW    = 32;
    localparam int DEPTH = 16;
`endif
    localparam int AW     = $clog2(DEPTH);
    localparam int AF_LVL = DEPTH - 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;

    buf_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue plus sticky flags and the last word delivered.
    logic [DW-1:0] mq[$];
    logic          m_ovf, m_udf, m_rvalid;
    logic [DW-1:0] m_rdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic model_edge(input logic f, input logic w, input logic [DW-1:0] d, input logic r);
        bit was_full, was_empty;
        if (f) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_rvalid = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_rvalid  = 1'b0;
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) begin
                m_rdata  = mq.pop_front();
                m_rvalid = 1'b1;
            end
            if (w && !was_full) mq.push_back(d);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n = mq.size();
        check_eq({tag, ":count"}, 64'(count), 64'(n));
        check_eq({tag, ":empty"}, 64'(empty), 64'(n == 0));
        check_eq({tag, ":full"}, 64'(full), 64'(n == DEPTH));
        check_eq({tag, ":afull"}, 64'(almost_full), 64'(n >= AF_LVL));
        check_eq({tag, ":ovf"}, 64'(ovf), 64'(m_ovf));
        check_eq({tag, ":udf"}, 64'(udf), 64'(m_udf));
`ifdef BUF_FIFO_FWFT_EN
        check_eq({tag, ":rd_valid"}, 64'(rd_valid), 64'(n > 0));
        if (n > 0) check_eq({tag, ":rd_data"}, 64'(rd_data), 64'(mq[0]));
`else
        check_eq({tag, ":rd_valid"}, 64'(rd_valid), 64'(m_rvalid));
        check_eq({tag, ":rd_data"}, 64'(rd_data), 64'(m_rdata));
`endif
    endtask

    task automatic step(input string tag, input logic f, input logic w, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        flush   = f;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        model_edge(f, w, d, r);
        #1;
        check_outputs(tag);
    endtask

    task automatic fill(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, DW'($urandom), 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 1..DEPTH, overflow attempt, drain in order.
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b0, 1'b1, DW'(i), 1'b0);
        step("ovf_wr", 1'b0, 1'b1, DW'(8'hFF), 1'b0);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b0, '0, 1'b1);
        step("flush0", 1'b1, 1'b0, '0, 1'b0);

        // Wrap-around.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) step("wrap_wr", 1'b0, 1'b1, DW'($urandom), 1'b0);
            for (int i = 0; i < 10; i++) step("wrap_rd", 1'b0, 1'b0, '0, 1'b1);
        end
        step("flush1", 1'b1, 1'b0, '0, 1'b0);

        // Simultaneous read/write at count 5, at full, at empty.
        fill("pre5", 5);
        for (int i = 0; i < 20; i++) step("rw5", 1'b0, 1'b1, DW'($urandom), 1'b1);
        step("flush2", 1'b1, 1'b0, '0, 1'b0);
        fill("prefull", DEPTH);
        step("rw_full", 1'b0, 1'b1, DW'($urandom), 1'b1);
        step("flush3", 1'b1, 1'b0, '0, 1'b0);
        step("rw_empty", 1'b0, 1'b1, DW'($urandom), 1'b1);
        step("rw_empty_rd", 1'b0, 1'b0, '0, 1'b1);

        // Flush overriding same-cycle requests.
        step("flush4", 1'b1, 1'b0, '0, 1'b0);
        fill("pre7", 7);
        step("flush_rw", 1'b1, 1'b1, DW'($urandom), 1'b1);

        // Asynchronous reset between edges mid-burst.
        fill("pre9", 9);
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        step("a5_wr", 1'b0, 1'b1, DW'(8'hA5), 1'b0);
        step("a5_rd", 1'b0, 1'b0, '0, 1'b1);
        step("a5_idle", 1'b0, 1'b0, '0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0),
                 DW'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/buf_fifo.md
# buf_fifo

Parametrised synchronous FIFO for the coprocessor datapath, replacing the fixed 32x16 buffer. Provides width/depth parameters, full/empty/almost-full status, occupancy count, overflow/underflow detection and synchronous flush. Sits between the instruction-side producer and the execute-side consumer. All logic is on one clock.

## Interface
- `DW`, 32 (`E203_XLEN`): data width in bits, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `AW`, `$clog2(DEPTH)`: entry address width; derived, not overridden.
- `AF_LVL`, `DEPTH-2`: almost-full threshold, 1..DEPTH.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `flush`  in  1  synchronous clear of pointers, count and flags.
- `wr_en`  in  1  write request.
- `wr_data`  in  DW  write data.
- `rd_en`  in  1  read request.
- `rd_data`  out  DW  read data.
- `rd_valid`  out  1  `rd_data` holds a valid word.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LVL.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `ovf`  out  1  sticky: a write was attempted while full.
- `udf`  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: DEPTH x DW array, not reset. Write pointer `wp` and read pointer `rp` are AW+1 bits; low AW bits address, MSB is the wrap bit.
- `empty` = (wp == rp); `full` = low bits equal and MSBs differ. `count` = wp − rp, modulo 2^(AW+1).
- Write accepted = `wr_en & !full`. The same-cycle read does not free a slot for the write; no full-side bypass.
- Read accepted = `rd_en & !empty`. A same-cycle write does not make an empty FIFO readable; no empty-side bypass.
- Accepted write: `ram[wp[AW-1:0]] <= wr_data`, wp += 1. Accepted read: rp += 1. Pointer increments wrap naturally at 2^(AW+1), with no compare-to-constant logic.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- `wr_en & full`: data is dropped, state is unchanged, `ovf` <= 1. `rd_en & empty`: ignored, `udf` <= 1. Both flags hold until `flush` or reset.
- `flush`: wp, rp <= 0; `ovf`, `udf`, `rd_valid` <= 0. It overrides any same-cycle wr_en/rd_en, and those requests do not set flags.
- Reset (any time, including mid-burst): wp = rp = 0, count 0, empty 1, full 0, almost_full 0 (AF_LVL ≥ 1), ovf 0, udf 0, rd_valid 0, rd_data 0 (registered mode). Array contents are undefined and never observable.

## Timing
- Status outputs (`full`, `empty`, `almost_full`, `count`) are registered-state derived. They update in the cycle after the accepting edge.
- Registered mode (default): `rd_data` is a register loaded on an accepted read. The value appears the cycle after rd_en; `rd_valid` is a 1-cycle pulse aligned with it. With no read, `rd_data` holds its last value.
- Back-to-back reads at one per cycle are supported. With N ≥ 1 words stored, N consecutive rd_en cycles yield N consecutive rd_valid cycles.
- Write-to-read latency: a word written at edge k can be read with rd_en in cycle k+1 (empty deasserts after edge k), giving data at k+2.

## Configuration
- `BUF_FIFO_FWFT_EN` defined: first-word-fall-through. `rd_data` = `ram[rp]` combinationally, `rd_valid` = !empty, and rd_en acts as a pop/acknowledge of the current head. Read latency is 0, and the head is visible the cycle after it is written.
- Undefined: registered-output mode as described under Timing.
- All flag, count, flush and error behaviour is identical in both modes.

## Test plan
- Reset, then write 16 words 0x1..0x10 (DEPTH=16) → full=1, count=16, almost_full asserted from count=14. A 17th write with 0xFF → dropped, ovf=1. Reading 16 words returns 0x1..0x10 in order, then empty=1.
- Wrap-around: 10 writes, 10 reads, 10 writes, 10 reads → data in order, count returns to 0, and no ovf/udf.
- Simultaneous rd/wr at count=5 for 20 cycles → count stays 5 and data order is preserved. The same operation at count=16 → read accepted, write dropped, ovf=1, count=15. The same at count=0 → write accepted, udf=1, count=1.
- Flush at count=7 with wr_en=rd_en=1 in the same cycle → next cycle count=0, empty=1, ovf=udf=0, rd_valid=0.
- Assert rst_n low asynchronously mid-burst (between edges, with count=9) → all outputs go to reset values immediately. After release, writing 0xA5 and reading it returns 0xA5.
- Repeat the first and third scenarios with `BUF_FIFO_FWFT_EN` and DW=8, DEPTH=4 → head is visible with zero read latency, and full is asserted at count=4.
